data_memory: RTL and testbench
==============================

Name: data_memory

Overview:
- Word-organised synchronous-write, combinational-read data memory for the MIPS datapath MEM stage.
- Accepts a 32-bit byte address from the ALU and a 32-bit store value from the register file.
- Returns a 32-bit load value to the write-back mux.
- One clock domain; asynchronous active-high reset clears the whole array.

Parameters:
- ADDR_BITS, 10, number of word-index bits; depth = 2**ADDR_BITS words (default 1024 words = 4 KiB).
- DATA_WIDTH, 32, word width in bits.

Ports:
- Clk  input  1  system clock; all writes occur on its rising edge.
- Reset  input  1  asynchronous, active-high reset; clears all memory words to 0.
- Address  input  32  byte address; bits [1:0] ignored (word aligned).
- WriteData  input  32  store data.
- MemWrite  input  1  write enable, sampled on rising Clk.
- MemRead  input  1  read enable, combinational.
- ReadData  output  32  load data.

Interface note: one clock; reset is asynchronous and active-high (ports named Clk and Reset).

Behaviour:
- Word index = Address[ADDR_BITS+1:2]. Address[1:0] is ignored, so byte addresses 0–3 all select word 0.
- In-range: Address[31:ADDR_BITS+2] == 0.
- Out-of-range writes are discarded.
- Out-of-range reads return 0.
- Reset asserted (any time, asynchronous): every word becomes 0 immediately. Writes are blocked while Reset is high. Reset has priority over a simultaneous MemWrite edge.
- Write: on rising Clk with Reset=0, MemWrite=1, address in range: mem[index] <= WriteData. Takes effect after that edge; no other word changes.
- MemWrite=0 at an edge: memory unchanged.
- Read: purely combinational, zero-cycle latency.
  - ReadData = mem[index] when MemRead=1 and address in range.
  - ReadData = 0 otherwise, including MemRead=0, out-of-range, or Reset high.
- ReadData reset value: 0.
- Read-during-write to the same word with MemRead=MemWrite=1: before the edge, ReadData shows the old word; after the edge, it shows the new word within the same delta, with no extra cycle.
- MemRead and MemWrite both high is legal. Both actions happen as above.
- X/undriven MemWrite must not corrupt memory in simulation. Treat it as a no-write (write only when MemWrite === 1 in the model; synthesis uses MemWrite==1).
- No handshake, no stall, no busy signal. The block is always ready.

Test Plan:
- Reset pulse (Reset=1 for 15 ns, then 0), MemRead=1, Address=0x0 -> ReadData=0x00000000 immediately; repeat for Address=0xFFC -> 0.
- MemRead=0, Address=0x1, WriteData=32 (0x20), MemWrite=1 for one rising edge, then MemWrite=0, MemRead=1 -> ReadData=0x00000020. Address=0x0, 0x2 and 0x3 also return 0x20, confirming word alignment.
- Write 0xDEADBEEF at 0x8 and 0x12345678 at 0xC on consecutive edges -> read 0x8 gives 0xDEADBEEF and read 0xC gives 0x12345678; drop MemRead -> ReadData=0.
- MemRead=1 and MemWrite=1 at Address 0x10 holding 0x11111111, WriteData=0x22222222 -> ReadData=0x11111111 before the edge and 0x22222222 just after.
- Out-of-range Address=0x00001000, write 0xAAAA5555 -> no word changes; read of 0x1000 returns 0, and read of 0x0 still returns its prior value.
- Write 0x5 at 0x4; assert Reset mid-cycle between edges -> ReadData at 0x4 becomes 0 without waiting for Clk. Reset held high across an edge with MemWrite=1 -> memory stays 0.

Source files
------------

// File: rtl/data_memory_if.sv
// Bus between the MEM stage and the data memory.
// The master drives the address, store data and enables; the slave returns the load word.
interface data_memory_if #(
  parameter int DATA_WIDTH = 32
);
  logic [31:0]           Address;
  logic [DATA_WIDTH-1:0] WriteData;
  logic                  MemWrite;
  logic                  MemRead;
  logic [DATA_WIDTH-1:0] ReadData;

  modport master (
    output Address, WriteData, MemWrite, MemRead,
    input  ReadData
  );

  modport slave (
    input  Address, WriteData, MemWrite, MemRead,
    output ReadData
  );
endinterface

// File: rtl/data_memory.sv
// Word-organised data memory for the MIPS MEM stage.
// Writes happen on the rising Clk edge; reads are combinational.
// Reset asynchronously clears every word.
module data_memory #(
  parameter int ADDR_BITS  = 10,
  parameter int DATA_WIDTH = 32
) (
  input logic         Clk,
  input logic         Reset,
  data_memory_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_BITS;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_BITS-1:0]  wordIdx;
  logic                  inRange;
  logic                  writeEn;
  logic                  unusedByteSel;

  // Byte-offset bits are ignored: the memory is word addressed only.
  assign wordIdx       = bus.Address[ADDR_BITS+1:2];
  assign unusedByteSel = ^bus.Address[1:0];

  // Any set bit above the word index means the access falls outside the array.
  assign inRange = (bus.Address[31:ADDR_BITS+2] == '0);

  // Case-equality keeps an X/undriven MemWrite from writing in simulation;
  // synthesis treats it as a plain equality compare.
  assign writeEn = (bus.MemWrite === 1'b1) && inRange;

  // Storage: async clear of the whole array, otherwise one word per write edge.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      mem <= '{default: '0};
    end else if (writeEn) begin
      mem[wordIdx] <= bus.WriteData;
    end
  end

  // Combinational load path; zero whenever the read is not enabled, out of range or in reset.
  always_comb begin
    bus.ReadData = '0;
    if (bus.MemRead && inRange && !Reset) begin
      bus.ReadData = mem[wordIdx];
    end
  end
endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: stimulus pushes expected load values into a
// scoreboard queue and signals a sample; a separate monitor pops and compares.
module tb_data_memory;
  typedef struct {
    logic [31:0] exp;
    string       nm;
  } exp_t;

  logic Clk;
  logic Reset;
  data_memory_if #(.DATA_WIDTH(32)) bus ();

  data_memory #(.ADDR_BITS(10), .DATA_WIDTH(32)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  exp_t sbq[$];
  event sampleEv;
  int   checks = 0;
  int   errors = 0;

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Monitor: on each sample request, compare the live load port to the queued value.
  initial begin
    exp_t e;
    forever begin
      @(sampleEv);
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underflow: sample requested with empty queue, ReadData=%h", bus.ReadData);
      end else begin
        e = sbq.pop_front();
        if (bus.ReadData !== e.exp) begin
          errors++;
          $display("FAIL %s: ReadData=%h expected=%h", e.nm, bus.ReadData, e.exp);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation timed out at %0t", $time);
    $fatal(1, "timeout");
  end

  // Present a read, let it settle, then hand the expectation to the monitor.
  task automatic chk(input logic [31:0] a, input logic rd, input logic [31:0] exp, input string nm);
    bus.Address = a;
    bus.MemRead = rd;
    #1;
    sbq.push_back('{exp: exp, nm: nm});
    ->sampleEv;
    #1;
  endtask

  // One write on a single rising edge, with MemRead low.
  task automatic doWrite(input logic [31:0] a, input logic [31:0] d);
    @(negedge Clk);
    bus.Address   = a;
    bus.WriteData = d;
    bus.MemRead   = 1'b0;
    bus.MemWrite  = 1'b1;
    @(posedge Clk);
    #1;
    bus.MemWrite  = 1'b0;
  endtask

  initial begin
    Reset         = 1'b1;
    bus.Address   = '0;
    bus.WriteData = '0;
    bus.MemWrite  = 1'b0;
    bus.MemRead   = 1'b0;

    // Reset pulse of 15 ns; loads read zero during and after it.
    chk(32'h0, 1'b1, 32'h0, "read_in_reset");
    #13;
    Reset = 1'b0;
    chk(32'h0,   1'b1, 32'h0, "post_reset_0x0");
    chk(32'hFFC, 1'b1, 32'h0, "post_reset_0xFFC");

    // Unaligned store lands in word 0; all four byte addresses alias to it.
    doWrite(32'h1, 32'h20);
    @(negedge Clk);
    chk(32'h1, 1'b0, 32'h0,  "memread_low_zero");
    chk(32'h1, 1'b1, 32'h20, "read_0x1");
    @(negedge Clk);
    chk(32'h0, 1'b1, 32'h20, "read_0x0_alias");
    chk(32'h2, 1'b1, 32'h20, "read_0x2_alias");
    @(negedge Clk);
    chk(32'h3, 1'b1, 32'h20, "read_0x3_alias");

    // Back-to-back stores on consecutive edges.
    doWrite(32'h8, 32'hDEADBEEF);
    doWrite(32'hC, 32'h12345678);
    @(negedge Clk);
    chk(32'h8, 1'b1, 32'hDEADBEEF, "read_0x8");
    chk(32'hC, 1'b1, 32'h12345678, "read_0xC");
    @(negedge Clk);
    chk(32'hC, 1'b0, 32'h0, "drop_memread");

    // Read-during-write on the same word: old value before the edge, new just after.
    doWrite(32'h10, 32'h11111111);
    @(negedge Clk);
    bus.WriteData = 32'h22222222;
    bus.MemWrite  = 1'b1;
    chk(32'h10, 1'b1, 32'h11111111, "rdw_before_edge");
    @(posedge Clk);
    chk(32'h10, 1'b1, 32'h22222222, "rdw_after_edge");
    bus.MemWrite = 1'b0;

    // Out-of-range store is dropped and must not alias onto word 0.
    doWrite(32'h1000, 32'hAAAA5555);
    @(negedge Clk);
    chk(32'h1000, 1'b1, 32'h0,  "oor_read_0x1000");
    chk(32'h0,    1'b1, 32'h20, "oor_word0_intact");
    @(negedge Clk);
    chk(32'h8000_0008, 1'b1, 32'h0, "oor_read_high");
    chk(32'h8, 1'b1, 32'hDEADBEEF, "oor_word2_intact");

    // Mid-cycle reset clears the array without a clock edge.
    doWrite(32'h4, 32'h5);
    @(negedge Clk);
    chk(32'h4, 1'b1, 32'h5, "read_0x4");
    Reset = 1'b1;
    chk(32'h4, 1'b1, 32'h0, "reset_mid_cycle");
    Reset = 1'b0;
    chk(32'h4, 1'b1, 32'h0, "cleared_0x4");
    @(negedge Clk);
    chk(32'h10, 1'b1, 32'h0, "cleared_0x10");

    // Reset held across a write edge blocks the write.
    @(negedge Clk);
    bus.Address   = 32'h4;
    bus.WriteData = 32'h99;
    bus.MemRead   = 1'b0;
    bus.MemWrite  = 1'b1;
    Reset         = 1'b1;
    @(posedge Clk);
    #1;
    bus.MemWrite = 1'b0;
    Reset        = 1'b0;
    chk(32'h4, 1'b1, 32'h0, "reset_blocks_write");

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 100 && sbq.size() != 0; i++) #1;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sbq.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
